// File: rtl/bsnn_readout.sv
// Spike-count readout: counts spikes per neuron over N_STEPS accepted timesteps, scans for the argmax, presents it on valid/ready.
// Optional drop counter built when BSNN_READOUT_DROP_CNT_EN is defined; otherwise drop_count is tied to 0.
//
// state    | meaning
// ST_ACCUM | accepting spike vectors, in_ready=1
// ST_SCAN  | comparing one neuron counter per cycle
// ST_HOLD  | result presented, waiting for out_ready
module bsnn_readout #(
    parameter int N_NEURONS = 4,
    parameter int N_STEPS   = 16,
    parameter int CNT_W     = $clog2(N_STEPS + 1),
    parameter int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [N_NEURONS-1:0] spikes,
    input  logic                 flush,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     out_class,
    output logic [CNT_W-1:0]     out_count,
    output logic [15:0]          drop_count
);

    typedef enum logic [1:0] {ST_ACCUM, ST_SCAN, ST_HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [N_NEURONS];
    logic [CNT_W-1:0] cnt_d [N_NEURONS];
    logic [CNT_W-1:0] step_q, step_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        idx_d      = idx_q;
        best_cnt_d = best_cnt_q;
        best_idx_d = best_idx_q;
        if (flush) begin
            // flush beats accept and handshake; the coincident vector is discarded
            for (int i = 0; i < N_NEURONS; i++) cnt_d[i] = '0;
            step_d     = '0;
            idx_d      = '0;
            best_cnt_d = '0;
            best_idx_d = '0;
            state_d    = ST_ACCUM;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (valid) begin
                        for (int i = 0; i < N_NEURONS; i++)
                            cnt_d[i] = cnt_q[i] + CNT_W'(spikes[i]);
                        step_d = step_q + 1'b1;
                        if (step_q == CNT_W'(N_STEPS - 1)) begin
                            idx_d      = '0;
                            best_cnt_d = '0;
                            best_idx_d = '0;
                            state_d    = ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    // strict compare keeps the lowest index on ties
                    if (cnt_q[idx_q] > best_cnt_q) begin
                        best_cnt_d = cnt_q[idx_q];
                        best_idx_d = idx_q;
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(N_NEURONS - 1)) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        for (int i = 0; i < N_NEURONS; i++) cnt_d[i] = '0;
                        step_d     = '0;
                        idx_d      = '0;
                        best_cnt_d = '0;
                        best_idx_d = '0;
                        state_d    = ST_ACCUM;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ACCUM;
            for (int i = 0; i < N_NEURONS; i++) cnt_q[i] <= '0;
            step_q     <= '0;
            idx_q      <= '0;
            best_cnt_q <= '0;
            best_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            idx_q      <= idx_d;
            best_cnt_q <= best_cnt_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign out_class = best_idx_q;
    assign out_count = best_cnt_q;

`ifdef BSNN_READOUT_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (valid && !in_ready && !flush && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 16'd0;
`endif

endmodule
